dma_ctrl: RTL and testbench

Single-channel DMA controller: the responder side of the CPU programming interface (cs / DB_wrReq / DB / wordcount / IORead / MemToMem) and the bus-requesting side of the HREQ/HACK handshake. The CPU programs a source address, a destination address, a word count and a direction. The block then requests the bus, moves words with read/write strobes, and signals completion on EOP. It sits between the CPU model and the shared memory / IO bus.

---
 rtl/dma_pkg.sv | 39 +++
 rtl/dma_addr_gen.sv | 63 ++++++
 rtl/dma_ctrl.sv | 147 ++++++++++++++
 tb/tb_dma_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and defaults for the single-channel DMA controller.
package dma_pkg;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 8;
    localparam int unsigned CW_DEF = 8;

    typedef enum logic [2:0] {
        StIdle,
        StProg,
        StArmed,
        StReq,
        StRd,
        StWr,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ModeIo2Mem,
        ModeMem2Io,
        ModeMem2Mem
    } mode_e;

    // Strobe vector layout: {mem_rd, mem_wr, io_rd, io_wr}
    localparam logic [3:0] STRB_MEM_RD = 4'b1000;
    localparam logic [3:0] STRB_MEM_WR = 4'b0100;
    localparam logic [3:0] STRB_IO_RD  = 4'b0010;
    localparam logic [3:0] STRB_IO_WR  = 4'b0001;

    function automatic mode_e decode_mode(input logic io_read, input logic mem_to_mem);
        if (mem_to_mem) begin
            return ModeMem2Mem;
        end else if (io_read) begin
            return ModeIo2Mem;
        end
        return ModeMem2Io;
    endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Source/destination address and word-count registers for the DMA channel.
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_src_i,
    input  logic          load_dst_i,
    input  logic          step_i,
    input  logic          src_inc_i,
    input  logic          dst_inc_i,
    input  logic [AW-1:0] db_i,
    input  logic [CW-1:0] wordcount_i,
    output logic [AW-1:0] src_nxt_o,
    output logic [AW-1:0] dst_nxt_o,
    output logic          cnt_zero_o,
    output logic          cnt_last_o
);

    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        cnt_d = cnt_q;
        if (load_src_i) begin
            src_d = db_i;
            cnt_d = wordcount_i;
        end
        if (load_dst_i) begin
            dst_d = db_i;
        end
        // IO-side addresses stay fixed; only memory-side pointers advance.
        if (step_i) begin
            cnt_d = cnt_q - CW'(1);
            if (src_inc_i) src_d = src_q + AW'(1);
            if (dst_inc_i) dst_d = dst_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
        end
    end

    assign src_nxt_o  = src_d;
    assign dst_nxt_o  = dst_d;
    assign cnt_zero_o = (cnt_q == '0);
    assign cnt_last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/dma_ctrl.sv
// Single-channel DMA controller: CPU programming port, HREQ/HACK bus handshake,
// and a two-cycle read/write word mover.
module dma_ctrl
    import dma_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          DB_wrReq,
    input  logic [DW-1:0] DB,
    input  logic [CW-1:0] wordcount,
    input  logic          IORead,
    input  logic          MemToMem,
    output logic          HREQ,
    input  logic          HACK,
    output logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          io_rd,
    output logic          io_wr,
    output logic          EOP,
    output logic          busy
);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [3:0]    strb_q, strb_d;
    logic          hreq_q, hreq_d;
    logic          eop_q, eop_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] tmp_q, tmp_d;

    logic          load_src, load_dst, step;
    logic [AW-1:0] src_nxt, dst_nxt;
    logic          cnt_zero, cnt_last;

    dma_addr_gen #(
        .AW(AW),
        .CW(CW)
    ) u_addr_gen (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_src_i (load_src),
        .load_dst_i (load_dst),
        .step_i     (step),
        .src_inc_i  (mode_q != ModeIo2Mem),
        .dst_inc_i  (mode_q != ModeMem2Io),
        .db_i       (AW'(DB)),
        .wordcount_i(wordcount),
        .src_nxt_o  (src_nxt),
        .dst_nxt_o  (dst_nxt),
        .cnt_zero_o (cnt_zero),
        .cnt_last_o (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        tmp_d    = tmp_q;
        load_src = 1'b0;
        load_dst = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cs && DB_wrReq) begin
                    load_src = 1'b1;
                    mode_d   = decode_mode(IORead, MemToMem);
                    state_d  = StProg;
                end
            end
            StProg: begin
                if (!cs) begin
                    state_d = StIdle;
                end else if (DB_wrReq) begin
                    load_dst = 1'b1;
                    state_d  = StArmed;
                end
            end
            StArmed: if (!cs) state_d = StReq;
            StReq:   if (HACK) state_d = cnt_zero ? StDone : StRd;
            StRd: begin
                if (HACK) begin
                    tmp_d   = data_in;
                    state_d = StWr;
                end
            end
            StWr: begin
                if (HACK) begin
                    step    = 1'b1;
                    state_d = cnt_last ? StDone : StRd;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        hreq_d = (state_d == StReq) || (state_d == StRd) || (state_d == StWr);
        eop_d  = (state_d == StDone);
        strb_d = '0;
        addr_d = addr_q;
        if (state_d == StRd) begin
            addr_d = src_nxt;
            strb_d = (mode_d == ModeIo2Mem) ? STRB_IO_RD : STRB_MEM_RD;
        end else if (state_d == StWr) begin
            addr_d = dst_nxt;
            strb_d = (mode_d == ModeMem2Io) ? STRB_IO_WR : STRB_MEM_WR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= ModeIo2Mem;
            strb_q  <= '0;
            hreq_q  <= 1'b0;
            eop_q   <= 1'b0;
            addr_q  <= '0;
            tmp_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            strb_q  <= strb_d;
            hreq_q  <= hreq_d;
            eop_q   <= eop_d;
            addr_q  <= addr_d;
            tmp_q   <= tmp_d;
        end
    end

    // A dropped grant suppresses the strobe for the stalled cycle.
    assign {mem_rd, mem_wr, io_rd, io_wr} = strb_q & {4{HACK}};
    assign HREQ     = hreq_q;
    assign EOP      = eop_q;
    assign busy     = (state_q != StIdle);
    assign addr     = addr_q;
    assign data_out = tmp_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl: cycle-exact vector table plus transfer sequences.
module tb_dma_ctrl;

    localparam logic [3:0] MRD = 4'b1000;
    localparam logic [3:0] MWR = 4'b0100;
    localparam logic [3:0] IRD = 4'b0010;
    localparam logic [3:0] IWR = 4'b0001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cs = 1'b0, db_wr = 1'b0, ior = 1'b0, m2m = 1'b0, hack = 1'b0;
    logic [7:0] db = '0, wc = '0, din = '0;
    logic       hreq, eop, busy, mem_rd, mem_wr, io_rd, io_wr;
    logic [7:0] addr, dout;
    logic [3:0] strb;

    assign strb = {mem_rd, mem_wr, io_rd, io_wr};

    always #5 clk = ~clk;

    dma_ctrl #(.AW(8), .DW(8), .CW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .DB_wrReq (db_wr),
        .DB       (db),
        .wordcount(wc),
        .IORead   (ior),
        .MemToMem (m2m),
        .HREQ     (hreq),
        .HACK     (hack),
        .addr     (addr),
        .data_in  (din),
        .data_out (dout),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .EOP      (eop),
        .busy     (busy)
    );

    typedef struct packed {
        logic       cs, wr;
        logic [7:0] db, wc;
        logic       ior, m2m, hack;
        logic [7:0] din;
        logic       hreq, eop, busy;
        logic [3:0] strb;
        logic [7:0] addr, dout;
    } vec_t;

    vec_t        vecs[15];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [11:0] exp_q[$];
    logic [11:0] ev_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  wr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Program, grant on first HREQ, log every strobe, and check latency from grant to EOP.
    task automatic run_xfer(input string name, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] c, input logic io_r, input logic mm,
                            input int drop_at, input int drop_len, input int rst_at,
                            input int exp_lat);
        int   lat = 0;
        int   stall_bad = 0;
        int   onehot_bad = 0;
        logic got_req = 1'b0;
        logic eop_hreq = 1'b1;
        ev_q.delete();
        rd_q.delete();
        wr_q.delete();
        tick(); cs = 1'b1; db_wr = 1'b1; db = s; wc = c; ior = io_r; m2m = mm;
        tick(); db = d;
        tick(); cs = 1'b0; db_wr = 1'b0; db = '0;
        for (int i = 0; i < 5 && !got_req; i++) begin
            tick();
            got_req = hreq;
        end
        check({name, " hreq_rise"}, 32'(got_req), 32'd1);
        hack = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            hack = !(k >= drop_at && k < drop_at + drop_len);
            din  = 8'(8'h40 + k);
            #1;
            if (!hack && (strb != 4'b0 || !hreq)) stall_bad++;
            if ($countones(strb) > 1) onehot_bad++;
            if (strb != 4'b0) begin
                ev_q.push_back({strb, addr});
                if (strb == MRD || strb == IRD) rd_q.push_back(din);
                else wr_q.push_back(dout);
            end
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check({name, " async_rst"}, 32'({hreq, busy, eop, strb}), 32'd0);
                tick();
                check({name, " rst_no_eop"}, 32'({eop, busy}), 32'd0);
                hack = 1'b0;
                rst = 1'b0;
                break;
            end
            if (eop) begin
                lat = k;
                eop_hreq = hreq;
                break;
            end
        end
        hack = 1'b0;
        din = '0;
        tick();
        check({name, " eop_latency"}, 32'(lat), 32'(exp_lat));
        if (exp_lat > 0) check({name, " hreq_low_at_eop"}, 32'(eop_hreq), 32'd0);
        if (drop_len > 0) check({name, " stall_quiet"}, 32'(stall_bad), 32'd0);
        check({name, " onehot"}, 32'(onehot_bad), 32'd0);
        check({name, " n_strobes"}, 32'(ev_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
            check($sformatf("%s ev%0d", name, i), 32'(ev_q[i]), 32'(exp_q[i]));
        for (int i = 0; i < wr_q.size() && i < rd_q.size(); i++)
            check($sformatf("%s data%0d", name, i), 32'(wr_q[i]), 32'(rd_q[i]));
    endtask

    initial begin
        // cs wr db wc ior m2m hack din | hreq eop busy strb addr dout
        vecs[0]  = '{1'b1, 1'b1, 8'd100, 8'd3, 1'b1, 1'b0, 1'b0, 8'h00,
                     1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h00,
                     1'b0, 1'b0, 1'b1, 4'h0, 8'd0, 8'h00};
        vecs[2]  = '{1'b1, 1'b1, 8'd100, 8'd3, 1'b1, 1'b0, 1'b0, 8'h00,
                     1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 8'd10, 8'd0, 1'b0, 1'b0, 1'b0, 8'h00,
                     1'b0, 1'b0, 1'b1, 4'h0, 8'd0, 8'h00};
        vecs[4]  = '{1'b1, 1'b1, 8'd55, 8'd0, 1'b0, 1'b0, 1'b0, 8'h00,
                     1'b0, 1'b0, 1'b1, 4'h0, 8'd0, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h00,
                     1'b0, 1'b0, 1'b1, 4'h0, 8'd0, 8'h00};
        vecs[6]  = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'h00,
                     1'b1, 1'b0, 1'b1, 4'h0, 8'd0, 8'h00};
        vecs[7]  = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'hA1,
                     1'b1, 1'b0, 1'b1, IRD, 8'd100, 8'h00};
        vecs[8]  = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'h00,
                     1'b1, 1'b0, 1'b1, MWR, 8'd10, 8'hA1};
        vecs[9]  = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'hB2,
                     1'b1, 1'b0, 1'b1, IRD, 8'd100, 8'hA1};
        vecs[10] = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'h00,
                     1'b1, 1'b0, 1'b1, MWR, 8'd11, 8'hB2};
        vecs[11] = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'hC3,
                     1'b1, 1'b0, 1'b1, IRD, 8'd100, 8'hB2};
        vecs[12] = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'h00,
                     1'b1, 1'b0, 1'b1, MWR, 8'd12, 8'hC3};
        vecs[13] = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h00,
                     1'b0, 1'b1, 1'b1, 4'h0, 8'd12, 8'hC3};
        vecs[14] = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h00,
                     1'b0, 1'b0, 1'b0, 4'h0, 8'd12, 8'hC3};

        #1 rst = 1'b1;
        #2 check("reset_outputs", 32'({hreq, eop, busy, strb, addr, dout}), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            tick();
            cs = vecs[i].cs; db_wr = vecs[i].wr; db = vecs[i].db; wc = vecs[i].wc;
            ior = vecs[i].ior; m2m = vecs[i].m2m; hack = vecs[i].hack; din = vecs[i].din;
            #1;
            check($sformatf("vec%0d", i), 32'({hreq, eop, busy, strb, addr, dout}),
                  32'({vecs[i].hreq, vecs[i].eop, vecs[i].busy, vecs[i].strb,
                       vecs[i].addr, vecs[i].dout}));
        end
        cs = 1'b0; db_wr = 1'b0; hack = 1'b0; din = '0;

        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({MRD, 8'(70 + i)});
            exp_q.push_back({MWR, 8'(100 + i)});
        end
        run_xfer("m2m", 8'd70, 8'd100, 8'd5, 1'b0, 1'b1, 0, 0, 0, 11);

        exp_q.delete();
        exp_q.push_back({MRD, 8'd254}); exp_q.push_back({IWR, 8'd45});
        exp_q.push_back({MRD, 8'd255}); exp_q.push_back({IWR, 8'd45});
        exp_q.push_back({MRD, 8'd0});   exp_q.push_back({IWR, 8'd45});
        run_xfer("m2io_wrap", 8'd254, 8'd45, 8'd3, 1'b0, 1'b0, 0, 0, 0, 7);

        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({IRD, 8'd20});
            exp_q.push_back({MWR, 8'(200 + i)});
        end
        run_xfer("hack_drop", 8'd20, 8'd200, 8'd3, 1'b1, 1'b0, 3, 3, 0, 10);

        exp_q.delete();
        run_xfer("wc_zero", 8'd9, 8'd9, 8'd0, 1'b1, 1'b0, 0, 0, 0, 1);

        exp_q.delete();
        exp_q.push_back({IRD, 8'd30}); exp_q.push_back({MWR, 8'd60});
        exp_q.push_back({IRD, 8'd30}); exp_q.push_back({MWR, 8'd61});
        run_xfer("rst_abort", 8'd30, 8'd60, 8'd4, 1'b1, 1'b0, 0, 0, 4, 0);

        exp_q.delete();
        exp_q.push_back({MRD, 8'd5}); exp_q.push_back({IWR, 8'd6});
        run_xfer("after_rst", 8'd5, 8'd6, 8'd1, 1'b0, 1'b0, 0, 0, 0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
